// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan scheduler: snapshots a packed value per frame, steps one digit per slot,
// and blanks the anodes at the start of every slot so the previous digit cannot ghost.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  localparam int SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic                CLK,
  input  logic                Rst,
  input  logic                iEn,
  input  logic                iLzb,
  input  logic [4*DIGITS-1:0] iData,
  input  logic [DIGITS-1:0]   iDpMask,
  output logic [3:0]          oNibble,
  output logic [DIGITS-1:0]   oAnode,
  output logic                oDp,
  output logic [SEL_W-1:0]    oDigitSel,
  output logic                oFrameDone
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_data_q, snap_data_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;

  logic [3:0]          nibble_q, nibble_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic                dp_q, dp_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                frame_done_q, frame_done_d;

  // Leading-zero detection runs on the snapshot that will be in effect after this edge.
  logic [DIGITS-1:0] nib_zero;
  logic [DIGITS-1:0] lead_zero;
  logic [DIGITS-1:0] blank_dig;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lzb
      assign nib_zero[gi] = (snap_data_d[4*gi +: 4] == 4'h0);
      if (gi == DIGITS - 1) begin : g_top
        assign lead_zero[gi] = nib_zero[gi];
      end else begin : g_mid
        assign lead_zero[gi] = nib_zero[gi] & lead_zero[gi+1];
      end
      if (gi == 0) begin : g_d0
        assign blank_dig[gi] = 1'b0;
      end else begin : g_dn
        assign blank_dig[gi] = iLzb & lead_zero[gi];
      end
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap_data_d  = snap_data_q;
    snap_dp_d    = snap_dp_q;
    frame_done_d = 1'b0;

    if (!iEn) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          snap_data_d = iData;
          snap_dp_d   = iDpMask;
          idx_d       = '0;
          cnt_d       = '0;
          state_d     = BLANK;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (idx_q == SEL_W'(DIGITS - 1)) begin
              idx_d        = '0;
              frame_done_d = 1'b1;
              snap_data_d  = iData;
              snap_dp_d    = iDpMask;
            end else begin
              idx_d = idx_q + SEL_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_comb begin
    nibble_d = 4'h0;
    anode_d  = '1;
    dp_d     = 1'b1;
    sel_d    = '0;
    if (state_d != IDLE) begin
      sel_d = idx_d;
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_d == SEL_W'(k)) begin
          nibble_d = snap_data_d[4*k +: 4];
          if (state_d == SHOW) begin
            dp_d = ~snap_dp_d[k];
            if (!blank_dig[k]) begin
              anode_d[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      nibble_q     <= 4'h0;
      anode_q      <= '1;
      dp_q         <= 1'b1;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      nibble_q     <= nibble_d;
      anode_q      <= anode_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign oNibble    = nibble_q;
  assign oAnode     = anode_q;
  assign oDp        = dp_q;
  assign oDigitSel  = sel_q;
  assign oFrameDone = frame_done_q;

endmodule
